// File: rtl/uart_packet_sequencer_if.sv
// Bus bundle between a host/transmitter and uart_packet_sequencer.
// master: the host side, which writes payload bytes, requests packets and
//         reports transmitter busy.
// slave:  the sequencer itself.
interface uart_packet_sequencer_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       send;
  logic       clear_crc;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       busy;
  logic [7:0] crc8;
  logic       done;

  modport master (
    output wr_en, wr_data, send, clear_crc, tx_busy,
    input  full, tx_start, tx_data, busy, crc8, done
  );

  modport slave (
    input  wr_en, wr_data, send, clear_crc, tx_busy,
    output full, tx_start, tx_data, busy, crc8, done
  );
endinterface

// File: rtl/uart_packet_sequencer.sv
// UART packet sequencer: buffers payload bytes in a small FIFO and, on request,
// hands a byte transmitter the frame SOF, payload..., CRC-8(payload), one byte
// at a time using a tx_start / tx_busy handshake.
module uart_packet_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter logic [7:0]  SOF   = 8'h7E,
  parameter logic [7:0]  POLY  = 8'h07
) (
  input  logic                  clock,
  input  logic                  reset,
  uart_packet_sequencer_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE,
    SEND_SOF,
    SEND_PAY,
    SEND_CRC,
    WAIT,
    FINISH
  } state_t;

  state_t          state;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   remaining;
  logic            crc_sent;
  logic            wait_first;
  logic [7:0]      crc_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            busy_q;
  logic            done_q;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic [7:0]      head;

  // One CRC-8 step over a whole byte, MSB first, no reflection.
  function automatic logic [7:0] crc_step(input logic [7:0] crc_in,
                                          input logic [7:0] data);
    logic [7:0] r;
    r = crc_in ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? POLY : 8'h00);
    end
    return r;
  endfunction

  // FIFO handshake decode: a pop happens exactly when a payload byte is issued.
  always_comb begin
    fifo_full = (count == CW'(DEPTH));
    push      = bus.wr_en && !fifo_full;
    pop       = (state == SEND_PAY) && !bus.tx_busy;
    head      = mem[rd_ptr];
  end

  // FIFO storage; no reset needed, validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet sequencing FSM with registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      crc_sent   <= 1'b0;
      wait_first <= 1'b0;
      crc_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.send) begin
            remaining <= count;
            crc_q     <= '0;
            crc_sent  <= 1'b0;
            busy_q    <= 1'b1;
            // SOF is issued straight from IDLE when the transmitter is free so
            // it appears the cycle after send; SEND_SOF only covers a busy tx.
            if (!bus.tx_busy) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= SOF;
              wait_first <= 1'b1;
              state      <= WAIT;
            end else begin
              state <= SEND_SOF;
            end
          end else if (bus.clear_crc) begin
            crc_q <= '0;
          end
        end
        SEND_SOF: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= SOF;
            wait_first <= 1'b1;
            state      <= WAIT;
          end
        end
        SEND_PAY: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= head;
            crc_q      <= crc_step(crc_q, head);
            remaining  <= remaining - CW'(1);
            wait_first <= 1'b1;
            state      <= WAIT;
          end
        end
        SEND_CRC: begin
          if (!bus.tx_busy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= crc_q;
            crc_sent   <= 1'b1;
            wait_first <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (wait_first) begin
            wait_first <= 1'b0;
          end else if (!bus.tx_busy) begin
            if (remaining != '0) begin
              state <= SEND_PAY;
            end else if (!crc_sent) begin
              state <= SEND_CRC;
            end else begin
              done_q <= 1'b1;
              state  <= FINISH;
            end
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Output drive.
  always_comb begin
    bus.full     = fifo_full;
    bus.tx_start = tx_start_q;
    bus.tx_data  = tx_data_q;
    bus.busy     = busy_q;
    bus.crc8     = crc_q;
    bus.done     = done_q;
  end

endmodule

// File: tb/tb_uart_packet_sequencer.sv
// Self-checking bench for uart_packet_sequencer: table of known packets,
// hand-written corner sequences and randomized packets against a queue model
// whose CRC is computed by augmented-message polynomial long division.
module tb_uart_packet_sequencer;

  localparam logic [7:0] SOF = 8'h7E;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    int         len;
    logic [71:0] payload;   // byte i at [8*i +: 8]
    int         busy;
    logic [7:0] exp_crc;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  uart_packet_sequencer_if ifc16 ();
  uart_packet_sequencer_if ifc8 ();

  uart_packet_sequencer #(.DEPTH(16), .SOF(SOF), .POLY(8'h07)) dut16 (
    .clock(clock), .reset(reset), .bus(ifc16)
  );
  uart_packet_sequencer #(.DEPTH(8), .SOF(SOF), .POLY(8'h07)) dut8 (
    .clock(clock), .reset(reset), .bus(ifc8)
  );

  int n_pass = 0;
  int n_total = 0;

  byte_q_t rx16;
  byte_q_t rx8;
  int done16 = 0;
  int done8 = 0;
  int viol = 0;
  int busy_cnt = 0;
  int xmit_cycles = 0;
  bit xmit_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Byte transmitter model for dut16 plus capture of both DUTs' output streams.
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt = 0;
      ifc16.tx_busy = 1'b0;
    end else begin
      if (ifc16.tx_start && ifc16.tx_busy) viol++;
      if (busy_cnt > 0) busy_cnt--;
      if (ifc16.tx_start) begin
        rx16.push_back(ifc16.tx_data);
        busy_cnt = xmit_rand ? int'($urandom_range(0, 4)) : xmit_cycles;
      end
      ifc16.tx_busy = (busy_cnt != 0);
      if (ifc16.done) done16++;
      if (ifc8.tx_start) rx8.push_back(ifc8.tx_data);
      if (ifc8.done) done8++;
    end
  end

  function automatic logic [7:0] crc_ref(input byte_q_t msg);
    logic [8:0] rem;
    logic [8:0] gen;
    logic [7:0] b;
    rem = '0;
    gen = {1'b1, 8'h07};
    for (int i = 0; i < msg.size() + 1; i++) begin
      b = (i < msg.size()) ? msg[i] : 8'h00;
      for (int k = 7; k >= 0; k--) begin
        rem = {rem[7:0], b[k]};
        if (rem[8]) rem = rem ^ gen;
      end
    end
    return rem[7:0];
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr16(input logic [7:0] d);
    ifc16.wr_en = 1'b1;
    ifc16.wr_data = d;
    tick();
    ifc16.wr_en = 1'b0;
  endtask

  task automatic send16();
    ifc16.send = 1'b1;
    tick();
    ifc16.send = 1'b0;
  endtask

  task automatic wait_idle16(input string name, input int budget);
    int n;
    n = 0;
    while (ifc16.busy && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle"}, ifc16.busy, 1'b0);
  endtask

  task automatic check_stream(input string name, input byte_q_t got, input byte_q_t req);
    check({name, "_len"}, got.size(), req.size());
    for (int i = 0; i < req.size() && i < got.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i), got[i], req[i]);
    end
  endtask

  vec_t tbl[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    byte_q_t exp_q;
    byte_q_t pay;
    byte_q_t model;
    int d0;
    int n;
    int k;
    int len;
    int extra;
    logic [7:0] d;
    logic [71:0] pl;

    tbl[0] = '{9, 72'h393837363534333231, 10, 8'hF4};
    tbl[1] = '{0, 72'h0, 3, 8'h00};
    tbl[2] = '{1, 72'h01, 0, 8'h07};
    tbl[3] = '{1, 72'h80, 1, 8'h89};
    tbl[4] = '{2, 72'h0000, 2, 8'h00};

    reset = 1'b1;
    ifc16.wr_en = 1'b0; ifc16.wr_data = '0; ifc16.send = 1'b0; ifc16.clear_crc = 1'b0;
    ifc8.wr_en = 1'b0;  ifc8.wr_data = '0;  ifc8.send = 1'b0;  ifc8.clear_crc = 1'b0;
    ifc8.tx_busy = 1'b0;
    repeat (3) tick();
    check("rst_full", ifc16.full, 1'b0);
    check("rst_busy", ifc16.busy, 1'b0);
    check("rst_done", ifc16.done, 1'b0);
    check("rst_tx_start", ifc16.tx_start, 1'b0);
    check("rst_tx_data", ifc16.tx_data, 8'h00);
    check("rst_crc8", ifc16.crc8, 8'h00);
    reset = 1'b0;
    tick();

    // Table of known packets.
    for (int v = 0; v < 5; v++) begin
      pl = tbl[v].payload;
      rx16.delete();
      exp_q.delete();
      d0 = done16;
      xmit_cycles = tbl[v].busy;
      exp_q.push_back(SOF);
      for (int i = 0; i < tbl[v].len; i++) begin
        wr16(pl[8*i +: 8]);
        exp_q.push_back(pl[8*i +: 8]);
      end
      exp_q.push_back(tbl[v].exp_crc);
      send16();
      wait_idle16($sformatf("tbl%0d", v), 600);
      tick();
      check_stream($sformatf("tbl%0d", v), rx16, exp_q);
      check($sformatf("tbl%0d_crc8", v), ifc16.crc8, tbl[v].exp_crc);
      check($sformatf("tbl%0d_done", v), done16 - d0, 1);
      check($sformatf("tbl%0d_txhold", v), ifc16.tx_data, tbl[v].exp_crc);
    end

    // Latency: SOF strobe the cycle after send, empty packet is SOF, 00.
    xmit_cycles = 0;
    rx16.delete();
    d0 = done16;
    ifc16.send = 1'b1;
    tick();
    ifc16.send = 1'b0;
    check("lat_tx_start", ifc16.tx_start, 1'b1);
    check("lat_tx_data", ifc16.tx_data, SOF);
    wait_idle16("lat", 100);
    check_stream("empty", rx16, '{SOF, 8'h00});
    check("empty_done", done16 - d0, 1);

    // Writes during transmission stay for the next packet; clear_crc ignored while busy.
    xmit_cycles = 5;
    wr16(8'hA5);
    wr16(8'h3C);
    rx16.delete();
    d0 = done16;
    send16();
    wr16(8'h11);
    wr16(8'h22);
    wr16(8'h33);
    ifc16.clear_crc = 1'b1;
    tick();
    ifc16.clear_crc = 1'b0;
    wait_idle16("mid1", 400);
    tick();
    pay = '{8'hA5, 8'h3C};
    exp_q = '{SOF, 8'hA5, 8'h3C, crc_ref(pay)};
    check_stream("mid1", rx16, exp_q);
    check("mid1_crc8", ifc16.crc8, crc_ref(pay));
    check("mid1_done", done16 - d0, 1);
    rx16.delete();
    d0 = done16;
    send16();
    wait_idle16("mid2", 400);
    tick();
    pay = '{8'h11, 8'h22, 8'h33};
    exp_q = '{SOF, 8'h11, 8'h22, 8'h33, crc_ref(pay)};
    check_stream("mid2", rx16, exp_q);
    check("mid2_crc8", ifc16.crc8, crc_ref(pay));
    ifc16.clear_crc = 1'b1;
    tick();
    ifc16.clear_crc = 1'b0;
    check("clear_idle_crc8", ifc16.crc8, 8'h00);

    // Reset in the middle of the payload.
    xmit_cycles = 3;
    for (int i = 1; i <= 4; i++) wr16(8'(i));
    rx16.delete();
    d0 = done16;
    send16();
    n = 0;
    while (rx16.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("mr_reached_pay", (rx16.size() >= 2), 1'b1);
    reset = 1'b1;
    #1;
    check("mr_tx_start", ifc16.tx_start, 1'b0);
    check("mr_tx_data", ifc16.tx_data, 8'h00);
    check("mr_busy", ifc16.busy, 1'b0);
    check("mr_done", ifc16.done, 1'b0);
    check("mr_crc8", ifc16.crc8, 8'h00);
    check("mr_full", ifc16.full, 1'b0);
    tick();
    reset = 1'b0;
    n = rx16.size();
    repeat (20) tick();
    check("mr_no_tx", rx16.size(), n);
    check("mr_no_done", done16 - d0, 0);
    rx16.delete();
    send16();
    wait_idle16("mr_after", 100);
    check_stream("mr_after", rx16, '{SOF, 8'h00});

    // DEPTH=8 instance: full after 8 writes, 9th dropped.
    for (int i = 0; i < 9; i++) begin
      ifc8.wr_en = 1'b1;
      ifc8.wr_data = 8'h40 + 8'(i);
      tick();
      ifc8.wr_en = 1'b0;
      if (i == 6) check("d8_full_after7", ifc8.full, 1'b0);
      if (i == 7) check("d8_full_after8", ifc8.full, 1'b1);
      if (i == 8) check("d8_full_after9", ifc8.full, 1'b1);
    end
    rx8.delete();
    ifc8.send = 1'b1;
    tick();
    ifc8.send = 1'b0;
    n = 0;
    while (ifc8.busy && n < 200) begin
      tick();
      n++;
    end
    check("d8_idle", ifc8.busy, 1'b0);
    pay.delete();
    exp_q.delete();
    exp_q.push_back(SOF);
    for (int i = 0; i < 8; i++) begin
      pay.push_back(8'h40 + 8'(i));
      exp_q.push_back(8'h40 + 8'(i));
    end
    exp_q.push_back(crc_ref(pay));
    check_stream("d8", rx8, exp_q);
    check("d8_done", done8, 1);
    check("d8_full_end", ifc8.full, 1'b0);

    // Randomized packets against the queue model.
    xmit_rand = 1'b1;
    model.delete();
    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 20);
      for (int i = 0; i < k; i++) begin
        d = 8'($urandom);
        wr16(d);
        if (model.size() < 16) model.push_back(d);
      end
      check($sformatf("rnd%0d_full", it), ifc16.full, (model.size() == 16));
      len = model.size();
      pay.delete();
      exp_q.delete();
      exp_q.push_back(SOF);
      for (int i = 0; i < len; i++) begin
        pay.push_back(model[i]);
        exp_q.push_back(model[i]);
      end
      exp_q.push_back(crc_ref(pay));
      rx16.delete();
      d0 = done16;
      send16();
      extra = $urandom_range(0, 16 - len);
      for (int i = 0; i < extra; i++) begin
        d = 8'($urandom);
        wr16(d);
        model.push_back(d);
      end
      wait_idle16($sformatf("rnd%0d", it), 600);
      tick();
      check_stream($sformatf("rnd%0d", it), rx16, exp_q);
      check($sformatf("rnd%0d_crc8", it), ifc16.crc8, crc_ref(pay));
      check($sformatf("rnd%0d_done", it), done16 - d0, 1);
      repeat (len) void'(model.pop_front());
    end

    check("tx_start_while_busy", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_packet_sequencer.md
UART_PACKET_SEQUENCER -- requirements
Module: uart_packet_sequencer

Interface
REQ-001 Parameter DEPTH, 8, payload FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter SOF, 8'h7E, start-of-frame byte sent first in every packet.
REQ-003 Parameter POLY, 8'h07, CRC-8 generator polynomial.
REQ-004 clock  in  1  single system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 wr_en  in  1  payload byte write strobe.
REQ-007 wr_data  in  8  payload byte.
REQ-008 full  out  1  FIFO holds DEPTH bytes.
REQ-009 send  in  1  one-cycle request to transmit one packet.
REQ-010 clear_crc  in  1  one-cycle request to zero crc8.
REQ-011 tx_start  out  1  one-cycle strobe to the byte transmitter.
REQ-012 tx_data  out  8  byte to transmit; valid while tx_start=1.
REQ-013 tx_busy  in  1  byte transmitter busy.
REQ-014 busy  out  1  packet in progress (state != IDLE).
REQ-015 crc8  out  8  running/final CRC of current or last packet payload.
REQ-016 done  out  1  one-cycle pulse when the last packet byte completes.

Function
REQ-017 FIFO: write accepted when wr_en=1 and full=0; write while full dropped, contents unchanged; pointers wrap modulo DEPTH.
REQ-018 Simultaneous write and internal read in one cycle both take effect; count unchanged.
REQ-019 States: IDLE, SEND_SOF, SEND_PAY, SEND_CRC, WAIT, FINISH.
REQ-020 IDLE: send=1 -> snapshot len = FIFO count, zero crc8, go SEND_SOF; send ignored in every other state.
REQ-021 Packet length equals the snapshot; bytes written after the snapshot stay in FIFO for the next packet.
REQ-022 SEND_x states issue tx_start only in a cycle with tx_busy=0, then go WAIT; with tx_busy=1 they hold.
REQ-023 WAIT ignores tx_busy in its first cycle, then waits for tx_busy=0; next state: SEND_PAY if payload bytes remain, else SEND_CRC if CRC not yet sent, else FINISH.
REQ-024 SEND_PAY pops one FIFO byte in the tx_start cycle and updates crc8 with that byte the same edge.
REQ-025 SEND_CRC transmits the crc8 value held at that cycle.
REQ-026 FINISH: done=1 for exactly one cycle, then IDLE; crc8 holds final value.
REQ-027 CRC-8: MSB first, init 8'h00, no reflection, no final XOR, over payload only (not SOF, not CRC byte).
REQ-028 len=0: packet is SOF then 8'h00.
REQ-029 clear_crc=1 in IDLE zeroes crc8 next edge; ignored while busy=1.
REQ-030 Latency: send in cycle N with tx_busy=0 -> tx_start with tx_data=SOF in cycle N+1.
REQ-031 tx_data holds its last value outside tx_start cycles.

Reset
REQ-032 reset=1 immediately forces IDLE, FIFO empty (full=0), crc8=8'h00, tx_start=0, tx_data=8'h00, busy=0, done=0.
REQ-033 Reset mid-packet abandons it without a done pulse; no tx_start until a new send after reset release.

Verification
REQ-034 Write "123456789" (8'h31..8'h39; DEPTH=16), send, transmitter model busy 10 cycles/byte -> tx_data sequence 7E,31..39,F4; crc8=F4; one done pulse.
REQ-035 Empty FIFO, send -> bytes 7E,00; done pulse; busy low afterward.
REQ-036 Write 9 bytes with DEPTH=8 -> full=1 after 8th; 9th dropped; packet carries first 8 only.
REQ-037 Write 2 bytes, send, write 3 more during transmission -> packet 7E,b0,b1,CRC; 3 bytes remain; second send transmits them.
REQ-038 Assert reset during SEND_PAY -> all outputs at reset values next sample, no done; clear_crc while busy -> crc8 unaffected.
